// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and its datapath (slave).
interface multicycle_ctrl_if;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        pc_src;
    logic [2:0]  state;
    logic        illegal;
    logic        retire;

    modport master (
        input  instruction, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, state, illegal, retire
    );

    modport slave (
        output instruction, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, state, illegal, retire
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Outputs are registered from the next state, so none of them follows mem_ready combinationally.
module multicycle_ctrl (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL
    } class_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       illegal;
        logic       retire;
    } ctl_t;

    state_t state, state_n;
    class_t cls, cls_n, opcode_cls;
    logic   is_bne, is_bne_n;
    logic   opcode_ok;
    logic   br_taken;
    ctl_t   ctl_q, ctl_n;
    logic   unused_insn_bits;

    assign unused_insn_bits = ^bus.instruction[31:15];

    always_comb begin
        opcode_ok  = 1'b1;
        opcode_cls = CL_R;
        case (bus.instruction[6:0])
            7'b0110011: opcode_cls = CL_R;
            7'b0010011: opcode_cls = CL_I;
            7'b0000011: opcode_cls = CL_LOAD;
            7'b0100011: opcode_cls = CL_STORE;
            7'b1100011: opcode_cls = CL_BRANCH;
            7'b1101111: opcode_cls = CL_JAL;
            default:    opcode_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        cls_n    = cls;
        is_bne_n = is_bne;
        case (state)
            FETCH: begin
                if (bus.mem_ready) state_n = DECODE;
            end
            DECODE: begin
                cls_n    = opcode_cls;
                is_bne_n = bus.instruction[12];
                if (!opcode_ok ||
                    (opcode_cls == CL_BRANCH && bus.instruction[14:13] != 2'b00))
                    state_n = TRAP;
                else
                    state_n = EXEC;
            end
            EXEC: begin
                case (cls)
                    CL_LOAD, CL_STORE: state_n = MEM;
                    CL_BRANCH:         state_n = FETCH;
                    default:           state_n = WB;
                endcase
            end
            MEM: begin
                if (bus.mem_ready) begin
                    if (cls == CL_LOAD) state_n = WB;
                    else                state_n = FETCH;
                end
            end
            WB:      state_n = FETCH;
            default: state_n = TRAP;
        endcase
    end

    // A store completes on the MEM->FETCH edge, so its retire pulse lands in the following FETCH cycle.
    always_comb begin
        ctl_n = '0;
        case (state_n)
            FETCH: begin
                ctl_n.mem_read  = 1'b1;
                ctl_n.alu_src_b = 2'd2;
                ctl_n.retire    = (state == MEM);
            end
            DECODE: begin
                ctl_n.ir_write = 1'b1;
                ctl_n.pc_write = 1'b1;
            end
            EXEC: begin
                ctl_n.alu_src_a = 1'b1;
                case (cls_n)
                    CL_R: begin
                        ctl_n.alu_op    = 2'd2;
                        ctl_n.alu_src_b = 2'd0;
                    end
                    CL_I: begin
                        ctl_n.alu_op    = 2'd2;
                        ctl_n.alu_src_b = 2'd1;
                    end
                    CL_BRANCH: begin
                        ctl_n.alu_op    = 2'd1;
                        ctl_n.alu_src_b = 2'd0;
                        ctl_n.retire    = 1'b1;
                    end
                    CL_JAL: begin
                        ctl_n.alu_src_a = 1'b0;
                        ctl_n.alu_src_b = 2'd1;
                        ctl_n.pc_write  = 1'b1;
                        ctl_n.pc_src    = 1'b1;
                    end
                    default: begin
                        ctl_n.alu_op    = 2'd0;
                        ctl_n.alu_src_b = 2'd1;
                    end
                endcase
            end
            MEM: begin
                ctl_n.alu_src_a = 1'b1;
                ctl_n.alu_src_b = 2'd1;
                ctl_n.mem_read  = (cls_n == CL_LOAD);
                ctl_n.mem_write = (cls_n == CL_STORE);
            end
            WB: begin
                ctl_n.reg_write  = (bus.instruction[11:7] != 5'd0);
                ctl_n.mem_to_reg = (cls_n == CL_LOAD);
                ctl_n.retire     = 1'b1;
            end
            default: ctl_n.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            cls             <= CL_R;
            is_bne          <= 1'b0;
            ctl_q           <= '0;
            ctl_q.mem_read  <= 1'b1;
            ctl_q.alu_src_b <= 2'd2;
        end else begin
            state  <= state_n;
            cls    <= cls_n;
            is_bne <= is_bne_n;
            ctl_q  <= ctl_n;
        end
    end

    // The zero flag is only valid during EXEC, so the branch redirect is resolved in that same cycle.
    assign br_taken = (state == EXEC) && (cls == CL_BRANCH) && (bus.zero != is_bne);

    assign bus.pc_write   = ctl_q.pc_write | br_taken;
    assign bus.pc_src     = ctl_q.pc_src | br_taken;
    assign bus.ir_write   = ctl_q.ir_write;
    assign bus.reg_write  = ctl_q.reg_write;
    assign bus.mem_read   = ctl_q.mem_read;
    assign bus.mem_write  = ctl_q.mem_write;
    assign bus.mem_to_reg = ctl_q.mem_to_reg;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.alu_op     = ctl_q.alu_op;
    assign bus.illegal    = ctl_q.illegal;
    assign bus.retire     = ctl_q.retire;
    assign bus.state      = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed programs plus random instruction streams,
// each expanded into an expected per-cycle output trace from the instruction's cycle schedule.
module tb_multicycle_ctrl;
    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_JAL = 5;
    localparam int K_BAD = 6;

    typedef struct {
        logic [31:0] insn;
        logic        rst;
        logic        mr;
        logic        z;
        logic [16:0] exp;
    } cyc_t;

    logic clk;
    logic rst;
    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cyc_t trace[$];
    bit   pend_retire;
    int   check_count;
    int   pass_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic rw, input logic mrd, input logic mwr,
                                       input logic m2r, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic ps, input logic ill,
                                       input logic ret);
        return {st, pcw, irw, rw, mrd, mwr, m2r, sa, sb, op, ps, ill, ret};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.illegal, bus.retire};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [31:0] insn, input logic r, input logic mr,
                                 input logic z, input logic [16:0] e);
        cyc_t c;
        c.insn = insn;
        c.rst  = r;
        c.mr   = mr;
        c.z    = z;
        c.exp  = e;
        trace.push_back(c);
    endfunction

    // Expands one instruction into its expected cycle schedule; abort_at >= 0 pulses reset in that MEM cycle.
    function automatic void build_insn(input int kind, input logic [31:0] insn, input int fw,
                                       input int mw, input logic zr, input int abort_at);
        logic        legal;
        logic        ld;
        logic        taken;
        logic [16:0] trapv;
        logic [16:0] memv;
        legal = (kind != K_BAD) && !(kind == K_BR && insn[14:12] > 3'd1);
        ld    = (kind == K_LD);
        taken = (insn[14:12] == 3'd1) ? !zr : zr;
        trapv = mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        memv  = mk(3'd3, 0, 0, 0, ld, kind == K_ST, 0, 1, 2'd1, 2'd0, 0, 0, 0);

        for (int i = 0; i <= fw; i++)
            push(insn, 0, i == fw, rb(),
                 mk(3'd0, 0, 0, 0, 1, 0, 0, 0, 2'd2, 2'd0, 0, 0, (i == 0) && pend_retire));
        pend_retire = 1'b0;
        push(insn, 0, rb(), rb(), mk(3'd1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0));

        if (!legal) begin
            for (int i = 0; i < 11; i++) push(insn, 0, rb(), rb(), trapv);
            push(insn, 1, rb(), rb(), trapv);
            return;
        end

        case (kind)
            K_R:   push(insn, 0, rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0, 0));
            K_I:   push(insn, 0, rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd2, 0, 0, 0));
            K_LD, K_ST:
                   push(insn, 0, rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0, 0));
            K_BR:  push(insn, 0, rb(), zr, mk(3'd2, taken, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, taken, 0, 1));
            default:
                   push(insn, 0, rb(), rb(), mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0, 0));
        endcase
        if (kind == K_BR) return;

        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i <= mw; i++) begin
                if (abort_at >= 0 && i == abort_at) begin
                    push(insn, 1, 0, rb(), memv);
                    return;
                end
                push(insn, 0, i == mw, rb(), memv);
            end
            if (kind == K_ST) begin
                pend_retire = 1'b1;
                return;
            end
        end

        push(insn, 0, rb(), rb(), mk(3'd4, 0, 0, insn[11:7] != 5'd0, 0, 0, ld, 0, 2'd0, 2'd0, 0, 0, 1));
    endfunction

    function automatic logic [31:0] make_insn(input int kind);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            K_R:   w[6:0] = 7'b0110011;
            K_I:   w[6:0] = 7'b0010011;
            K_LD:  w[6:0] = 7'b0000011;
            K_ST:  w[6:0] = 7'b0100011;
            K_JAL: w[6:0] = 7'b1101111;
            K_BR: begin
                w[6:0]   = 7'b1100011;
                w[14:12] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7))
                                                       : 3'($urandom_range(0, 1));
            end
            default: begin
                case ($urandom_range(0, 2))
                    0:       w[6:0] = 7'h7F;
                    1:       w[6:0] = 7'h37;
                    default: w[6:0] = 7'h17;
                endcase
            end
        endcase
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    // Drives one cycle's inputs half a period before the sampling edge and lets outputs settle.
    task automatic applyStimulus(input cyc_t c);
        @(negedge clk);
        rst             = c.rst;
        bus.instruction = c.insn;
        bus.mem_ready   = c.mr;
        bus.zero        = c.z;
        #1;
    endtask

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [16:0] got, input logic [16:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        int kind;
        check_count     = 0;
        pass_count      = 0;
        pend_retire     = 1'b0;
        rst             = 1'b1;
        bus.instruction = 32'h0;
        bus.mem_ready   = 1'b0;
        bus.zero        = 1'b0;
        repeat (2) @(posedge clk);

        // Directed programs: add, lw with slow memory, beq both ways, illegal opcode, addi x0, aborted sw.
        build_insn(K_R,   32'h003100B3, 0, 0, 1'b0, -1);
        build_insn(K_LD,  32'h0080A283, 0, 3, 1'b0, -1);
        build_insn(K_BR,  32'h00208463, 0, 0, 1'b1, -1);
        build_insn(K_BR,  32'h00208463, 1, 0, 1'b0, -1);
        build_insn(K_BAD, 32'h0000007F, 0, 0, 1'b0, -1);
        build_insn(K_I,   32'h00100013, 0, 0, 1'b0, -1);
        build_insn(K_ST,  32'h0050A423, 0, 5, 1'b0, 2);
        build_insn(K_ST,  32'h0050A423, 0, 0, 1'b0, -1);
        build_insn(K_JAL, 32'h008000EF, 0, 0, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            kind = ($urandom_range(0, 13) == 0) ? K_BAD : int'($urandom_range(0, 5));
            build_insn(kind, make_insn(kind), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), rb(), -1);
        end

        foreach (trace[i]) begin
            applyStimulus(trace[i]);
            checkOutput($sformatf("cyc%0d_state%0d", i, trace[i].exp[16:14]), dut_vec(), trace[i].exp);
        end

        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
